// File: rtl/rx_serial_8n1.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// registered byte/command/framing-error outputs and a one-cycle frame strobe.
module rx_serial_8n1 #(
    parameter int         CLK_FREQ = 50000000,
    parameter int         BAUD     = 115200,
    parameter logic [7:0] CMD_CODE = 8'h23
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] dados,
    output logic       fim_recepcao,
    output logic       comando,
    output logic       erro_framing,
    output logic [3:0] dbEstado
);

    localparam int TICKS = CLK_FREQ / BAUD;
    localparam int TW    = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'b0000,
        START  = 4'b0001,
        DATA   = 4'b0010,
        STOP   = 4'b0011,
        DONE   = 4'b0100,
        ESPERA = 4'b0101
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            dados        <= '0;
            fim_recepcao <= 1'b0;
            comando      <= 1'b0;
            erro_framing <= 1'b0;
        end else begin
            fim_recepcao <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        tick_cnt  <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            state <= DONE;
                        end else begin
                            erro_framing <= 1'b1;
                            state        <= ESPERA;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DONE: begin
                    fim_recepcao <= 1'b1;
                    dados        <= shift_reg;
                    comando      <= (shift_reg == CMD_CODE);
                    erro_framing <= 1'b0;
                    state        <= IDLE;
                end
                // Hold off until the line returns high so a break is not re-decoded.
                ESPERA: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dbEstado = 4'b1111;
        case (state)
            IDLE:    dbEstado = 4'b0000;
            START:   dbEstado = 4'b0001;
            DATA:    dbEstado = 4'b0010;
            STOP:    dbEstado = 4'b0011;
            DONE:    dbEstado = 4'b0100;
            ESPERA:  dbEstado = 4'b0101;
            default: dbEstado = 4'b1111;
        endcase
    end

endmodule

// File: tb/tb_rx_serial_8n1.sv
// Self-checking bench for rx_serial_8n1: frames are queued as expectations when
// driven and compared when the receiver strobes fim_recepcao.
`timescale 1ns/1ps
module tb_rx_serial_8n1;

    localparam int BIT_CYC = 16;

    logic       clock;
    logic       reset;
    logic       RX;
    logic [7:0] dados;
    logic       fim_recepcao;
    logic       comando;
    logic       erro_framing;
    logic [3:0] dbEstado;

    typedef struct {
        logic [7:0] b;
        int         c0;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_item;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulse  = 0;
    int   cyc      = 0;
    int   lat;
    bit   width_pending = 0;

    rx_serial_8n1 #(
        .CLK_FREQ (1600),
        .BAUD     (100),
        .CMD_CODE (8'h23)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .RX           (RX),
        .dados        (dados),
        .fim_recepcao (fim_recepcao),
        .comando      (comando),
        .erro_framing (erro_framing),
        .dbEstado     (dbEstado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller must be sitting on a falling clock edge; each bit lasts BIT_CYC cycles.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        exp_t       e;
        frame = {stop_bit, b, 1'b0};
        if (stop_bit) begin
            e.b  = b;
            e.c0 = cyc;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            repeat (BIT_CYC) @(negedge clock);
        end
    endtask

    always @(negedge clock) begin
        if (width_pending) begin
            chk("pulse_width", fim_recepcao, 0);
            width_pending = 0;
        end
        if (fim_recepcao) begin
            n_pulse++;
            width_pending = 1;
            chk("queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_item = exp_q.pop_front();
                chk("dados", dados, exp_item.b);
                chk("comando", comando, exp_item.b == 8'h23);
                chk("erro_framing_pulse", erro_framing, 0);
                lat = cyc - exp_item.c0;
                if (lat < 154 || lat > 156)
                    $display("note: latency %0d cycles", lat);
                chk("latency_window", (lat >= 154 && lat <= 156), 1);
            end
        end
    end

    initial begin
        RX    = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_dados", dados, 8'h00);
        chk("rst_fim", fim_recepcao, 0);
        chk("rst_comando", comando, 0);
        chk("rst_erro", erro_framing, 0);
        chk("rst_estado", dbEstado, 4'b0000);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        send_byte(8'h55, 1'b1);
        repeat (4) @(negedge clock);
        send_byte(8'h23, 1'b1);
        repeat (4) @(negedge clock);
        send_byte(8'h41, 1'b1);
        repeat (10) @(negedge clock);

        // Glitch: 4 low cycles must be rejected at the mid-start sample.
        RX = 1'b0;
        repeat (4) @(negedge clock);
        RX = 1'b1;
        repeat (2) @(negedge clock);
        chk("glitch_in_start", dbEstado, 4'b0001);
        repeat (20) @(negedge clock);
        chk("glitch_back_idle", dbEstado, 4'b0000);
        chk("glitch_dados_kept", dados, 8'h41);

        // Framing error followed by a held-low line.
        send_byte(8'h7E, 1'b0);
        repeat (20) @(negedge clock);
        chk("ferr_estado", dbEstado, 4'b0101);
        chk("ferr_flag", erro_framing, 1);
        chk("ferr_dados_kept", dados, 8'h41);
        chk("ferr_comando_kept", comando, 0);
        repeat (20) @(negedge clock);
        RX = 1'b1;
        repeat (6) @(negedge clock);
        chk("ferr_back_idle", dbEstado, 4'b0000);
        chk("ferr_sticky", erro_framing, 1);
        send_byte(8'h31, 1'b1);
        repeat (4) @(negedge clock);
        chk("ferr_cleared", erro_framing, 0);

        send_byte(8'h01, 1'b1);
        send_byte(8'h80, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (10) @(negedge clock);
        chk("b2b_last", dados, 8'hFF);

        // Reset in the middle of the data bits.
        RX = 1'b0;
        repeat (BIT_CYC) @(negedge clock);
        RX = 1'b1;
        repeat (BIT_CYC) @(negedge clock);
        RX = 1'b0;
        repeat (10) @(negedge clock);
        chk("pre_reset_busy", dbEstado, 4'b0010);
        reset = 1'b0;
        RX    = 1'b1;
        repeat (2) @(negedge clock);
        chk("mid_rst_dados", dados, 8'h00);
        chk("mid_rst_fim", fim_recepcao, 0);
        chk("mid_rst_comando", comando, 0);
        chk("mid_rst_erro", erro_framing, 0);
        chk("mid_rst_estado", dbEstado, 4'b0000);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        send_byte(8'hA5, 1'b1);
        repeat (30) @(negedge clock);

        chk("queue_drained", exp_q.size(), 0);
        chk("pulse_count", n_pulse, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_serial_8n1.md
Name: rx_serial_8n1

Overview:
- UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Sits directly upstream of the lock control unit and drives its reception-done and command inputs.
- Each valid frame produces a byte, a one-cycle fim_recepcao pulse, and a comando flag that classifies the byte as command or data.
- Framing errors are flagged and never produce fim_recepcao.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- CMD_CODE, 8'h23, byte value ('#') classified as a command.
- TICKS, derived as CLK_FREQ/BAUD with integer truncation (434 at defaults); clock cycles per bit; TICKS >= 4 is required.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- RX  input  1  serial line, idles high, asynchronous to clock.
- dados  output  8  last valid received byte.
- fim_recepcao  output  1  one-cycle pulse marking a valid frame.
- comando  output  1  1 when dados == CMD_CODE; valid with dados.
- erro_framing  output  1  stop bit sampled low on the last frame.
- dbEstado  output  4  current FSM state code, for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to idle, counters are cleared, shift register is cleared.
  - Both synchronizer flops are set to 1.
  - Outputs: dados=8'h00, fim_recepcao=0, comando=0, erro_framing=0, dbEstado=4'b0000.
  - Deasserting reset mid-frame restarts cleanly; the next falling edge on the line is treated as a start bit.
- Input synchronizer: RX passes through 2 flip-flops; rx_s is the synchronized value and all decisions use rx_s.
- tick_cnt counts 0..TICKS-1; bit_cnt counts 0..7.
- FSM states (dbEstado code):
  - idle (0000): wait for rx_s=0; then go to start and clear tick_cnt.
  - start (0001): when tick_cnt == TICKS/2-1, sample rx_s.
    - rx_s=0: go to data, clear tick_cnt and bit_cnt.
    - rx_s=1: false start (glitch); return to idle with no output change.
  - data (0010): when tick_cnt == TICKS-1, shift rx_s into the MSB of the shift register (right shift, so LSB-first data lands correctly) and clear tick_cnt.
    - After the 8th sample (bit_cnt == 7), go to stop; otherwise increment bit_cnt.
  - stop (0011): when tick_cnt == TICKS-1, sample rx_s.
    - rx_s=1: go to done.
    - rx_s=0: set erro_framing=1, leave dados and comando unchanged, go to espera_linha.
  - done (0100): for exactly one cycle, fim_recepcao=1, dados<=shift register, comando<=(shift register == CMD_CODE), erro_framing<=0; next state is idle.
  - espera_linha (0101): stay until rx_s=1, then go to idle. This prevents a break condition from being decoded as repeated frames.
  - Unused codes: go to idle; dbEstado=4'b1111.
- Output timing:
  - dados and comando are registered, update only in done, and hold until the next valid frame.
  - fim_recepcao is registered and high for exactly 1 cycle per valid frame.
  - erro_framing is sticky until the next valid frame or reset.
- Latency: fim_recepcao rises at TICKS/2 + 9*TICKS + 1 (done) + 2 (synchronizer) clock cycles after the RX falling edge, ±1 cycle for synchronizer phase.
- Back-to-back frames:
  - done returns to idle in 1 cycle, so a start bit immediately following the stop bit is accepted.
  - The stop bit is sampled mid-bit, leaving half a bit of margin.
- Downstream contract: the consumer samples dados and comando in the cycle fim_recepcao=1 or any later cycle before the next frame completes; no backpressure exists.

Test Plan:
- Common bench setup: CLK_FREQ=1600, BAUD=100 (TICKS=16).
- Frame 0x55 (RX sequence 0,1,0,1,0,1,0,1,0,1) -> single fim_recepcao pulse; dados=8'h55, comando=0, erro_framing=0; pulse within 16/2+9*16+3 ±1 = 155 ±1 cycles of the RX falling edge.
- Frame 0x23 -> dados=8'h23, comando=1. A following frame 0x41 -> dados=8'h41, comando=0. One pulse per frame.
- RX low for 4 cycles, then high (glitch) -> dbEstado returns 0000 after start; fim_recepcao never asserts; dados unchanged.
- Frame 0x7E with stop bit driven 0, RX held low 40 cycles, then high -> erro_framing=1, no fim_recepcao, dados keeps its prior value, dbEstado passes through 0101 to 0000. A following valid 0x31 -> erro_framing=0, dados=8'h31.
- Three frames 0x01, 0x80, 0xFF sent with zero idle gap -> three pulses; dados=01, 80, FF in order.
- reset=0 asserted mid data bits of a frame, released, then frame 0xA5 sent -> all outputs at reset values during reset; afterwards exactly one pulse with dados=8'hA5.
